// File: rtl/debug_stream_controller.sv
// Handshaked debug streamer for the Connect Four core: single-beat cell/status reads and a
// multi-beat board snapshot dump. Define DEBUG_CHECKSUM_EN to append an XOR checksum beat to dumps.
module debug_stream_controller #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int CELL_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        e_debug,
  input  logic [ROWS*COLS*CELL_W-1:0] board_in,
  input  logic [2:0]                  current_col,
  input  logic [1:0]                  winner,
  input  logic [7:0]                  uio_in,
  input  logic                        cmd_stb,
  input  logic                        ack,
  output logic [7:0]                  uio_out,
  output logic [7:0]                  uio_oe,
  output logic                        resp_valid,
  output logic                        resp_last,
  output logic                        busy
);

  localparam int NCELLS = ROWS * COLS;
  localparam int NBEATS = (NCELLS + 2) / 3;
  localparam int SNAP_W = NBEATS * 6;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_DUMP
`ifdef DEBUG_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_READ_CELL,
    CMD_READ_STATUS,
    CMD_DUMP
  } cmd_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        single_q, single_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
`ifdef DEBUG_CHECKSUM_EN
  logic [5:0]        csum_q, csum_d;
`endif

  cmd_t             cmd;
  logic [2:0]       arg_row;
  logic [2:0]       arg_col;
  logic [CELL_W-1:0] cell_data;
  logic [5:0]       beat_data;
  logic [5:0]       resp_data;

  assign cmd     = cmd_t'(uio_in[1:0]);
  assign arg_row = uio_in[7:5];
  assign arg_col = uio_in[4:2];

  // Scanning only in-range cells makes out-of-range row/col addresses read back as zero.
  always_comb begin
    cell_data = '0;
    for (int i = 0; i < NCELLS; i++) begin
      if ((int'(arg_row) == i / COLS) && (int'(arg_col) == i % COLS))
        cell_data = board_in[i*CELL_W +: CELL_W];
    end
  end

  // The snapshot register is zero-padded past the last cell, so partial final beats pad with 0.
  assign beat_data = snap_q[6*int'(cnt_q) +: 6];

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    snap_d   = snap_q;
`ifdef DEBUG_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (!e_debug) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_stb) begin
            case (cmd)
              CMD_READ_CELL: begin
                state_d  = S_SINGLE;
                single_d = 6'(cell_data);
              end
              CMD_READ_STATUS: begin
                state_d  = S_SINGLE;
                single_d = {1'b0, winner, current_col};
              end
              CMD_DUMP: begin
                state_d = S_DUMP;
                cnt_d   = '0;
                snap_d  = SNAP_W'(board_in);
`ifdef DEBUG_CHECKSUM_EN
                csum_d  = '0;
`endif
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
        S_SINGLE: begin
          if (ack) state_d = S_IDLE;
        end
        S_DUMP: begin
          if (ack) begin
`ifdef DEBUG_CHECKSUM_EN
            csum_d = csum_q ^ beat_data;
`endif
            if (cnt_q == LAST_BEAT) begin
              cnt_d = '0;
`ifdef DEBUG_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef DEBUG_CHECKSUM_EN
        S_CSUM: begin
          if (ack) state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the snapshot is reset too, so a dump interrupted by reset leaves no stale board behind.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      single_q <= '0;
      snap_q   <= '0;
`ifdef DEBUG_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      snap_q   <= snap_d;
`ifdef DEBUG_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    resp_data = '0;
    resp_last = 1'b0;
    case (state_q)
      S_SINGLE: begin
        resp_data = single_q;
        resp_last = 1'b1;
      end
      S_DUMP: begin
        resp_data = beat_data;
`ifndef DEBUG_CHECKSUM_EN
        resp_last = (cnt_q == LAST_BEAT);
`endif
      end
`ifdef DEBUG_CHECKSUM_EN
      S_CSUM: begin
        resp_data = csum_q;
        resp_last = 1'b1;
      end
`endif
      default: begin
        resp_data = '0;
        resp_last = 1'b0;
      end
    endcase
  end

  assign resp_valid = (state_q != S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign uio_out    = {resp_data, 2'b00};
  assign uio_oe     = resp_valid ? 8'hFC : 8'h00;

endmodule

// File: tb/tb_debug_stream_controller.sv
// Directed bench for debug_stream_controller: expected beats are queued when a command is
// issued and compared as the DUT presents them.
`timescale 1ns/1ps
module tb_debug_stream_controller;

  localparam int NCELLS = 64;
  localparam int NBEATS = 22;

  logic         clk = 1'b0;
  logic         rst, en, en6, cmd_stb, ack;
  logic [127:0] board;
  logic [2:0]   current_col;
  logic [1:0]   winner;
  logic [7:0]   uio_in;

  logic [7:0]   uio_out, uio_oe;
  logic         resp_valid, resp_last, busy;
  logic [7:0]   uio_out6, uio_oe6;
  logic         resp_valid6, resp_last6, busy6;

  typedef struct packed {
    logic [5:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  debug_stream_controller #(.ROWS(8), .COLS(8), .CELL_W(2)) dut (
    .clk(clk), .rst(rst), .e_debug(en), .board_in(board),
    .current_col(current_col), .winner(winner), .uio_in(uio_in),
    .cmd_stb(cmd_stb), .ack(ack), .uio_out(uio_out), .uio_oe(uio_oe),
    .resp_valid(resp_valid), .resp_last(resp_last), .busy(busy)
  );

  // Six-row instance used only to exercise an out-of-range row address.
  debug_stream_controller #(.ROWS(6), .COLS(8), .CELL_W(2)) dut6 (
    .clk(clk), .rst(rst), .e_debug(en6), .board_in(board[95:0]),
    .current_col(current_col), .winner(winner), .uio_in(uio_in),
    .cmd_stb(cmd_stb), .ack(ack), .uio_out(uio_out6), .uio_oe(uio_oe6),
    .resp_valid(resp_valid6), .resp_last(resp_last6), .busy(busy6)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cell(input int r, input int c, input logic [1:0] v);
    board[2*(r*8+c) +: 2] = v;
  endtask

  task automatic push_dump(input logic [127:0] b);
    logic [5:0] d;
    logic [5:0] cs;
    cs = '0;
    for (int k = 0; k < NBEATS; k++) begin
      d = '0;
      for (int j = 0; j < 3; j++)
        if (3*k + j < NCELLS) d[2*j +: 2] = b[2*(3*k+j) +: 2];
      cs ^= d;
`ifdef DEBUG_CHECKSUM_EN
      sb.push_back('{d, 1'b0});
`else
      sb.push_back('{d, (k == NBEATS-1)});
`endif
    end
`ifdef DEBUG_CHECKSUM_EN
    sb.push_back('{cs, 1'b1});
`endif
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [5:0] arg);
    uio_in  = {arg, cmd};
    cmd_stb = 1'b1;
    @(negedge clk);
    cmd_stb = 1'b0;
    uio_in  = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, resp_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_oe"},    uio_oe, 8'h00);
    check({tag, "_out"},   uio_out, 8'h00);
    check({tag, "_last"},  resp_last, 0);
  endtask

  // Acks every cycle and requires a valid beat each cycle until the queue drains.
  task automatic run_beats(input string tag);
    beat_t e;
    ack = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_valid"}, resp_valid, 1);
      check({tag, "_data"},  uio_out, {24'd0, e.data, 2'b00});
      check({tag, "_last"},  resp_last, e.last);
      check({tag, "_oe"},    uio_oe, 8'hFC);
      @(negedge clk);
    end
    ack = 1'b0;
    check_idle({tag, "_end"});
  endtask

  initial begin
    beat_t e;
    rst = 1'b1; en = 1'b0; en6 = 1'b0; cmd_stb = 1'b0; ack = 1'b0;
    uio_in = '0; board = '0; current_col = '0; winner = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Strobes with debug disabled are ignored
    for (int i = 0; i < 3; i++) begin
      issue(2'd3, 6'd0);
      check("disabled_busy", busy, 0);
    end
    en = 1'b1;

    // NOP leaves the block idle
    issue(2'd0, 6'd0);
    check_idle("nop");

    // READ_CELL (2,5) with distinct neighbours; held without ack, strobe while busy ignored
    set_cell(2, 5, 2'b10);
    set_cell(5, 2, 2'b01);
    set_cell(2, 4, 2'b11);
    set_cell(3, 5, 2'b11);
    sb.push_back('{6'b000010, 1'b1});
    issue(2'd1, 6'b010_101);
    for (int i = 0; i < 4; i++) begin
      check("hold_data", uio_out, 8'b0000_1000);
      check("hold_valid", resp_valid, 1);
      cmd_stb = (i == 1);
      uio_in  = (i == 1) ? 8'h03 : 8'h00;
      @(negedge clk);
    end
    cmd_stb = 1'b0;
    uio_in  = '0;
    run_beats("cell");

    // READ_STATUS sampled at accept edge
    winner = 2'b01;
    current_col = 3'd6;
    sb.push_back('{6'b001110, 1'b1});
    issue(2'd2, 6'd0);
    winner = 2'b10;
    current_col = 3'd1;
    run_beats("status");

    // Row 7 is valid on the 8-row board
    set_cell(7, 0, 2'b11);
    sb.push_back('{6'b000011, 1'b1});
    issue(2'd1, 6'b111_000);
    run_beats("row7");

    // Row 7 is out of range on the 6-row board
    en = 1'b0;
    en6 = 1'b1;
    board[95:0] = {48{2'b11}};
    issue(2'd1, 6'b111_000);
    check("oob_valid", resp_valid6, 1);
    check("oob_data", uio_out6, 8'h00);
    check("oob_last", resp_last6, 1);
    check("oob_oe", uio_oe6, 8'hFC);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("oob_busy_end", busy6, 0);
    en6 = 1'b0;
    en = 1'b1;

    // Full dump of cell i = i%4, board changed right after accept
    for (int i = 0; i < NCELLS; i++) board[2*i +: 2] = 2'(i % 4);
    push_dump(board);
    issue(2'd3, 6'd0);
    board = ~board;
    run_beats("dump");

    // Single non-zero cell and all-zero board
    board = '0;
    board[1:0] = 2'b11;
    push_dump(board);
    issue(2'd3, 6'd0);
    run_beats("dump_c0");
    board = '0;
    push_dump(board);
    issue(2'd3, 6'd0);
    run_beats("dump_zero");

    // Abort after beat 5, ack on the same edge
    for (int i = 0; i < NCELLS; i++) board[2*i +: 2] = 2'(i % 4);
    push_dump(board);
    issue(2'd3, 6'd0);
    ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e = sb.pop_front();
      check("abort_pre_data", uio_out, {24'd0, e.data, 2'b00});
      @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    check_idle("abort");
    sb.delete();
    en = 1'b1;
    for (int i = 0; i < 4; i++) board[32*i +: 32] = $urandom;
    push_dump(board);
    issue(2'd3, 6'd0);
    run_beats("redump");

    // Reset in the middle of a dump
    push_dump(board);
    issue(2'd3, 6'd0);
    ack = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    winner = 2'b11;
    current_col = 3'd2;
    sb.push_back('{6'b011010, 1'b1});
    issue(2'd2, 6'd0);
    run_beats("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
